dmem_port_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline's MEM stage (core) and a burst DMA/loader engine. The core keeps fixed priority every cycle. A starvation counter forces one DMA beat, stalling the core for that one cycle, after `STARVE_LIMIT` consecutive denied cycles. The block sits between the MEM-stage memory signals and the data memory, and feeds `C_Stall` into the hazard unit as an extra freeze of F/D/E/M.

---
 rtl/dmem_port_arbiter.sv | 90 +++++++++
 tb/tb_dmem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the MEM-stage core and a burst DMA engine.
// The core has fixed priority; a starvation counter forces one DMA beat after STARVE_LIMIT denied cycles.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        C_Req,
  input  logic        C_We,
  input  logic [31:0] C_Addr,
  input  logic [31:0] C_WData,
  output logic [31:0] C_RData,
  output logic        C_Stall,
  input  logic        D_Start,
  input  logic        D_Dir,
  input  logic [31:0] D_Base,
  input  logic [3:0]  D_Len,
  input  logic        D_Abort,
  input  logic [31:0] D_WData,
  input  logic        D_WValid,
  output logic        D_WReady,
  output logic [31:0] D_RData,
  output logic        D_RValid,
  output logic        D_Busy,
  output logic        D_Done,
  output logic        M_We,
  output logic [31:0] M_Addr,
  output logic [31:0] M_WData,
  input  logic [31:0] M_RData
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [31:0] addr;
  logic [3:0]  beatsLeft;
  logic [3:0]  starve;
  logic        dir;
  logic        dmaPending;
  logic        dmaWin;

  always_comb begin
    dmaPending = (state == BURST) & (~dir | D_WValid);
    dmaWin     = dmaPending & (~C_Req | (starve == LIMIT));
    C_Stall    = C_Req & dmaWin;
    M_Addr     = dmaWin ? addr : C_Addr;
    M_WData    = dmaWin ? D_WData : C_WData;
    // Gated by reset so no stray core write reaches memory while the block is held in reset.
    M_We       = Reset_n & (dmaWin ? dir : (C_Req & C_We));
    D_WReady   = dmaWin & dir;
    C_RData    = M_RData;
    D_Busy     = state != IDLE;
    D_Done     = state == DONE;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      beatsLeft <= '0;
      starve    <= '0;
      dir       <= 1'b0;
      D_RData   <= '0;
      D_RValid  <= 1'b0;
    end else begin
      D_RValid <= dmaWin & ~dir;
      if (dmaWin & ~dir) D_RData <= M_RData;
      if (dmaWin) begin
        addr      <= addr + 32'd4;
        beatsLeft <= beatsLeft - 4'd1;
        starve    <= '0;
      end else if (dmaPending && starve != LIMIT) begin
        starve <= starve + 4'd1;
      end
      if (state == IDLE && D_Start) begin
        addr      <= D_Base;
        beatsLeft <= D_Len;
        dir       <= D_Dir;
        starve    <= '0;
        state     <= BURST;
      end else if (state == BURST) begin
        state <= D_Abort ? IDLE : (dmaWin && beatsLeft == 4'd0) ? DONE : BURST;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenario tasks against a small word-addressed memory model.
module tb_dmem_port_arbiter;
  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        C_Req = 0, C_We = 0, C_Stall;
  logic [31:0] C_Addr = 0, C_WData = 0, C_RData;
  logic        D_Start = 0, D_Dir = 0, D_Abort = 0, D_WValid = 0;
  logic [31:0] D_Base = 0, D_WData = 0, D_RData;
  logic [3:0]  D_Len = 0;
  logic        D_WReady, D_RValid, D_Busy, D_Done, M_We;
  logic [31:0] M_Addr, M_WData, M_RData;
  logic [31:0] mem [0:255];
  int nTests = 0;
  int nFail = 0;

  dmem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .C_Req(C_Req), .C_We(C_We), .C_Addr(C_Addr), .C_WData(C_WData), .C_RData(C_RData), .C_Stall(C_Stall),
    .D_Start(D_Start), .D_Dir(D_Dir), .D_Base(D_Base), .D_Len(D_Len), .D_Abort(D_Abort),
    .D_WData(D_WData), .D_WValid(D_WValid), .D_WReady(D_WReady), .D_RData(D_RData), .D_RValid(D_RValid),
    .D_Busy(D_Busy), .D_Done(D_Done), .M_We(M_We), .M_Addr(M_Addr), .M_WData(M_WData), .M_RData(M_RData)
  );

  always #5 CLK = ~CLK;
  assign M_RData = mem[M_Addr[9:2]];
  always @(posedge CLK) if (M_We) mem[M_Addr[9:2]] <= M_WData;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearAll();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    C_Req = 0; C_We = 0; C_Addr = 0; C_WData = 0;
    D_Start = 0; D_Dir = 0; D_Base = 0; D_Len = 0; D_Abort = 0; D_WData = 0; D_WValid = 0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nTests++;
    if ({D_Busy, D_Done, D_RValid, C_Stall, M_We, D_WReady} !== 6'b0 || D_RData !== 32'h0) begin
      nFail++;
      $display("FAIL reset_outputs got busy=%b done=%b rvalid=%b stall=%b we=%b wready=%b rdata=%h want all 0",
               D_Busy, D_Done, D_RValid, C_Stall, M_We, D_WReady, D_RData);
    end
    step();
    Reset_n = 1;
    step();
  endtask

  task automatic test_uncontended_read();
    logic expV;
    clearAll();
    mem[8'h40] = 1; mem[8'h41] = 2; mem[8'h42] = 3; mem[8'h43] = 4;
    D_Start = 1; D_Base = 32'h100; D_Len = 3; D_Dir = 0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge CLK);
      expV = (c >= 2 && c <= 5);
      nTests++;
      if (D_RValid !== expV || (expV && D_RData !== 32'(c - 1))) begin
        nFail++;
        $display("FAIL rd_rvalid c=%0d got v=%b d=%h want v=%b d=%h", c, D_RValid, D_RData, expV, c - 1);
      end
      nTests++;
      if (D_Done !== (c == 5)) begin
        nFail++;
        $display("FAIL rd_done c=%0d got %b want %b", c, D_Done, (c == 5));
      end
      nTests++;
      if (D_Busy !== (c >= 1 && c <= 5)) begin
        nFail++;
        $display("FAIL rd_busy c=%0d got %b want %b", c, D_Busy, (c >= 1 && c <= 5));
      end
      step();
      D_Start = 0;
    end
  endtask

  task automatic test_starvation();
    int bad;
    logic [31:0] want;
    clearAll();
    C_Req = 1; C_We = 1; D_WValid = 1; D_Dir = 1; D_Base = 32'h300; D_Len = 1; D_Start = 1;
    for (int c = 0; c <= 11; c++) begin
      C_Addr = 32'h200 + 32'(4 * c);
      C_WData = 32'hC000 + 32'(c);
      D_WData = 32'hDA00_0000 | 32'(c);
      @(negedge CLK);
      nTests++;
      if (C_Stall !== (c == 5 || c == 10)) begin
        nFail++;
        $display("FAIL starve_stall c=%0d got %b want %b", c, C_Stall, (c == 5 || c == 10));
      end
      step();
      D_Start = 0;
    end
    C_Req = 0; C_We = 0;
    nTests++;
    if (mem[8'hC0] !== 32'hDA00_0005 || mem[8'hC1] !== 32'hDA00_000A) begin
      nFail++;
      $display("FAIL starve_dma_words got %h %h want DA000005 DA00000A", mem[8'hC0], mem[8'hC1]);
    end
    bad = 0;
    for (int c = 0; c <= 11; c++) begin
      want = (c == 5 || c == 10) ? 32'h0 : 32'hC000 + 32'(c);
      if (mem[8'h80 + c] !== want) bad++;
    end
    nTests++;
    if (bad != 0) begin
      nFail++;
      $display("FAIL starve_core_writes got %0d wrong words want 0", bad);
    end
  endtask

  task automatic test_write_backpressure();
    logic [7:0] vPat;
    logic expR;
    vPat = 8'b0011_0010;
    clearAll();
    D_Dir = 1; D_Base = 32'h180; D_Len = 2; D_Start = 1;
    for (int c = 0; c <= 7; c++) begin
      D_WValid = vPat[c];
      D_WData = 32'hB0 + 32'(c);
      @(negedge CLK);
      expR = vPat[c];
      nTests++;
      if (D_WReady !== expR || dut.starve !== 4'd0) begin
        nFail++;
        $display("FAIL bp_wready c=%0d got wready=%b starve=%0d want wready=%b starve=0", c, D_WReady, dut.starve, expR);
      end
      nTests++;
      if (D_Done !== (c == 6)) begin
        nFail++;
        $display("FAIL bp_done c=%0d got %b want %b", c, D_Done, (c == 6));
      end
      step();
      D_Start = 0;
    end
    nTests++;
    if (mem[8'h60] !== 32'hB1 || mem[8'h61] !== 32'hB4 || mem[8'h62] !== 32'hB5) begin
      nFail++;
      $display("FAIL bp_words got %h %h %h want B1 B4 B5", mem[8'h60], mem[8'h61], mem[8'h62]);
    end
  endtask

  task automatic test_wrap_busy();
    logic [31:0] expA [0:3];
    logic [31:0] expD [0:3];
    logic expV;
    expA = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    expD = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
    clearAll();
    mem[8'hFE] = 32'hE1; mem[8'hFF] = 32'hE2; mem[8'h00] = 32'hE3; mem[8'h01] = 32'hE4;
    D_Start = 1; D_Base = 32'hFFFF_FFF8; D_Len = 3; D_Dir = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 2) begin
        D_Start = 1; D_Base = 32'h100; D_Len = 0;
      end
      @(negedge CLK);
      if (c >= 1 && c <= 4) begin
        nTests++;
        if (M_Addr !== expA[c - 1]) begin
          nFail++;
          $display("FAIL wrap_addr c=%0d got %h want %h", c, M_Addr, expA[c - 1]);
        end
      end
      expV = (c >= 2 && c <= 5);
      nTests++;
      if (D_RValid !== expV || (expV && D_RData !== expD[c - 2])) begin
        nFail++;
        $display("FAIL wrap_rdata c=%0d got v=%b d=%h want v=%b", c, D_RValid, D_RData, expV);
      end
      nTests++;
      if (D_Done !== (c == 5) || D_Busy !== (c >= 1 && c <= 5)) begin
        nFail++;
        $display("FAIL wrap_busy_done c=%0d got busy=%b done=%b want busy=%b done=%b", c, D_Busy, D_Done,
                 (c >= 1 && c <= 5), (c == 5));
      end
      step();
      D_Start = 0;
    end
  endtask

  task automatic test_abort();
    int nValid;
    int nDone;
    clearAll();
    mem[8'h40] = 1; mem[8'h41] = 2; mem[8'h42] = 3;
    nValid = 0; nDone = 0;
    D_Start = 1; D_Base = 32'h100; D_Len = 7; D_Dir = 0;
    for (int c = 0; c <= 8; c++) begin
      D_Abort = (c == 2);
      @(negedge CLK);
      if (D_RValid) nValid++;
      if (D_Done) nDone++;
      if (c == 3) begin
        nTests++;
        if (D_Busy !== 1'b0 || D_RValid !== 1'b1 || D_RData !== 32'd2) begin
          nFail++;
          $display("FAIL abort_next got busy=%b v=%b d=%h want busy=0 v=1 d=2", D_Busy, D_RValid, D_RData);
        end
      end
      step();
      D_Start = 0;
    end
    nTests++;
    if (nValid != 2 || nDone != 0) begin
      nFail++;
      $display("FAIL abort_beats got beats=%0d done=%0d want beats=2 done=0", nValid, nDone);
    end
  endtask

  task automatic test_reset_midburst();
    logic expV;
    clearAll();
    mem[8'h40] = 1; mem[8'h41] = 2; mem[8'h42] = 3;
    D_Start = 1; D_Base = 32'h100; D_Len = 3; D_Dir = 0;
    step();
    D_Start = 0;
    step();
    #1 Reset_n = 0;
    #1;
    nTests++;
    if ({D_Busy, D_Done, D_RValid, C_Stall, M_We, D_WReady} !== 6'b0 || D_RData !== 32'h0) begin
      nFail++;
      $display("FAIL midreset_outputs got busy=%b done=%b v=%b stall=%b we=%b wready=%b d=%h want all 0",
               D_Busy, D_Done, D_RValid, C_Stall, M_We, D_WReady, D_RData);
    end
    step();
    Reset_n = 1;
    step();
    D_Start = 1; D_Base = 32'h104; D_Len = 1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge CLK);
      expV = (c == 2 || c == 3);
      nTests++;
      if (D_RValid !== expV || (expV && D_RData !== 32'(c)) || D_Done !== (c == 3)) begin
        nFail++;
        $display("FAIL postreset_burst c=%0d got v=%b d=%h done=%b want v=%b d=%h done=%b", c, D_RValid, D_RData,
                 D_Done, expV, c, (c == 3));
      end
      step();
      D_Start = 0;
    end
  endtask

  initial begin
    clearAll();
    test_reset();
    test_uncontended_read();
    test_starvation();
    test_write_backpressure();
    test_wrap_busy();
    test_abort();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
